// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU/MDU requesters and the GPR write-port arbiter.
// Carries three valid/ready write requests, the registered GPR write port and the
// contention counter; forwarding taps exist only when WB_FWD_EN is defined.
interface gpr_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wa;
  logic [DATA_W-1:0] alu_wd;
  logic              alu_ready;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_wa;
  logic [DATA_W-1:0] lsu_wd;
  logic              lsu_ready;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_wa;
  logic [DATA_W-1:0] mdu_wd;
  logic              mdu_ready;
  logic              gpr_we;
  logic [ADDR_W-1:0] gpr_wa;
  logic [DATA_W-1:0] gpr_wd;
  logic [CNT_W-1:0]  contention_cnt;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd,
           mdu_valid, mdu_wa, mdu_wd, ra1, ra2,
    input  alu_ready, lsu_ready, mdu_ready, gpr_we, gpr_wa, gpr_wd,
           contention_cnt, fwd1_hit, fwd2_hit, fwd_data
  );
  modport slave (
    input  alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd,
           mdu_valid, mdu_wa, mdu_wd, ra1, ra2,
    output alu_ready, lsu_ready, mdu_ready, gpr_we, gpr_wa, gpr_wd,
           contention_cnt, fwd1_hit, fwd2_hit, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd,
           mdu_valid, mdu_wa, mdu_wd,
    input  alu_ready, lsu_ready, mdu_ready, gpr_we, gpr_wa, gpr_wd,
           contention_cnt
  );
  modport slave (
    input  alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd,
           mdu_valid, mdu_wa, mdu_wd,
    output alu_ready, lsu_ready, mdu_ready, gpr_we, gpr_wa, gpr_wd,
           contention_cnt
  );
`endif
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among ALU, LSU and MDU.
// Latency: grant in cycle N -> registered gpr_we/wa/wd in N+1; one write per cycle.
// Backpressure: ready is a combinational one-hot grant, all readies 0 during reset.
// Optional macro WB_FWD_EN adds combinational decode-forwarding taps on the write stage.
module gpr_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           reset,
  gpr_wb_arbiter_if.slave bus
);

  // Source encoding for the round-robin "last granted" pointer.
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_MDU = 2'd2;

  logic [1:0]        last_q, last_d;
  logic              gpr_we_q, gpr_we_d;
  logic [ADDR_W-1:0] gpr_wa_q, gpr_wa_d;
  logic [DATA_W-1:0] gpr_wd_q, gpr_wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        vld;
  logic [2:0]        gnt;
  logic [1:0]        gnt_src;
  logic [ADDR_W-1:0] sel_wa;
  logic [DATA_W-1:0] sel_wd;
  logic              contended;

  assign vld       = {bus.mdu_valid, bus.lsu_valid, bus.alu_valid};
  assign contended = (vld[0] & vld[1]) | (vld[0] & vld[2]) | (vld[1] & vld[2]);

  // Grant the first valid source after the last winner; nothing is granted in reset.
  always_comb begin
    gnt = 3'b000;
    if (!reset) begin
      case (last_q)
        SRC_ALU: begin
          if      (vld[1]) gnt = 3'b010;
          else if (vld[2]) gnt = 3'b100;
          else if (vld[0]) gnt = 3'b001;
        end
        SRC_LSU: begin
          if      (vld[2]) gnt = 3'b100;
          else if (vld[0]) gnt = 3'b001;
          else if (vld[1]) gnt = 3'b010;
        end
        default: begin
          if      (vld[0]) gnt = 3'b001;
          else if (vld[1]) gnt = 3'b010;
          else if (vld[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  // Steer the granted source's address/data toward the write stage.
  always_comb begin
    gnt_src = SRC_ALU;
    sel_wa  = bus.alu_wa;
    sel_wd  = bus.alu_wd;
    if (gnt[1]) begin
      gnt_src = SRC_LSU;
      sel_wa  = bus.lsu_wa;
      sel_wd  = bus.lsu_wd;
    end else if (gnt[2]) begin
      gnt_src = SRC_MDU;
      sel_wa  = bus.mdu_wa;
      sel_wd  = bus.mdu_wd;
    end
  end

  // Next state: load the write stage on a grant (r0 loads but never enables), bump the counter.
  always_comb begin
    last_d   = last_q;
    gpr_we_d = 1'b0;
    gpr_wa_d = gpr_wa_q;
    gpr_wd_d = gpr_wd_q;
    cnt_d    = cnt_q;
    if (|gnt) begin
      last_d   = gnt_src;
      gpr_we_d = (sel_wa != '0);
      gpr_wa_d = sel_wa;
      gpr_wd_d = sel_wd;
    end
    if (contended && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any pending write and re-arms ALU as first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= SRC_MDU;
      gpr_we_q <= 1'b0;
      gpr_wa_q <= '0;
      gpr_wd_q <= '0;
      cnt_q    <= '0;
    end else begin
      last_q   <= last_d;
      gpr_we_q <= gpr_we_d;
      gpr_wa_q <= gpr_wa_d;
      gpr_wd_q <= gpr_wd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.alu_ready      = gnt[0];
  assign bus.lsu_ready      = gnt[1];
  assign bus.mdu_ready      = gnt[2];
  assign bus.gpr_we         = gpr_we_q;
  assign bus.gpr_wa         = gpr_wa_q;
  assign bus.gpr_wd         = gpr_wd_q;
  assign bus.contention_cnt = cnt_q;

`ifdef WB_FWD_EN
  // Expose the in-flight write so decode can bypass the register file.
  assign bus.fwd1_hit = gpr_we_q && (gpr_wa_q == bus.ra1) && (bus.ra1 != '0);
  assign bus.fwd2_hit = gpr_we_q && (gpr_wa_q == bus.ra2) && (bus.ra2 != '0);
  assign bus.fwd_data = gpr_wd_q;
`endif

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port (we3/wa3/wd3) among three writeback sources: ALU, load/store unit (LSU) and multiply/divide unit (MDU).
- Uses a round-robin grant with valid/ready handshakes and one registered output stage.
- Sits between the execute/memory stages and the register file.
- Also drops writes to r0 and counts writeback contention cycles for performance debug.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU has a write pending
- alu_wa  input  ADDR_W  ALU destination register
- alu_wd  input  DATA_W  ALU write data
- alu_ready  output  1  ALU write accepted this cycle
- lsu_valid  input  1  LSU has a write pending
- lsu_wa  input  ADDR_W  LSU destination register
- lsu_wd  input  DATA_W  LSU write data
- lsu_ready  output  1  LSU write accepted this cycle
- mdu_valid  input  1  MDU has a write pending
- mdu_wa  input  ADDR_W  MDU destination register
- mdu_wd  input  DATA_W  MDU write data
- mdu_ready  output  1  MDU write accepted this cycle
- gpr_we  output  1  to GPR we3
- gpr_wa  output  ADDR_W  to GPR wa3
- gpr_wd  output  DATA_W  to GPR wd3
- contention_cnt  output  CNT_W  cycles with more than one valid requester, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Reset values:
  - gpr_we=0, gpr_wa=0, gpr_wd=0, contention_cnt=0.
  - Round-robin pointer last=MDU, so ALU has first priority after reset.
  - While reset is high, all readies are 0.
- Handshake:
  - A transfer occurs in a cycle where x_valid=1 and x_ready=1.
  - Requesters hold valid, wa and wd stable until ready.
  - Ready is combinational from the valids and the pointer. It never depends on ready itself.
- Grant:
  - At most one ready per cycle.
  - Search order starts at the source after "last": ALU->LSU->MDU->ALU.
  - The first valid source found is granted.
  - "last" updates to the granted source on a grant and holds otherwise.
- Latency:
  - A grant in cycle N registers gpr_we/gpr_wa/gpr_wd, which are visible in cycle N+1.
  - The GPR commits the write at the end of cycle N+1.
  - Throughput is one write per cycle. There are no bubbles while requests are pending.
- No grant in cycle N: gpr_we=0 in N+1. gpr_wa and gpr_wd hold their previous values.
- r0 writes:
  - A granted request with wa=0 completes its handshake (ready=1) and advances the pointer.
  - The registered gpr_we is 0 for it. gpr_wa and gpr_wd still load.
- Same destination from two sources in one cycle: writes are serialised in grant order. The later grant's data is final.
- contention_cnt: increments by 1 each cycle in which two or more valids are high. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: the pending registered write is discarded (gpr_we=0 next cycle). Requesters re-present their requests after reset.
- Fairness: with all three sources continuously valid, grants rotate ALU, LSU, MDU, ALU, ...

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds these ports:
  - ra1 input ADDR_W
  - ra2 input ADDR_W
  - fwd1_hit output 1
  - fwd2_hit output 1
  - fwd_data output DATA_W
- fwd1_hit = gpr_we && gpr_wa==ra1 && ra1!=0. fwd2_hit is the same for ra2. fwd_data = gpr_wd.
- All forwarding outputs are combinational. They let decode forward the in-flight write before the GPR commits it.
- When not defined, these ports do not exist and no comparators are built.

Test Plan:
- Reset, then ALU only: alu_valid=1, wa=3, wd=0x11111111.
  - Required: alu_ready=1 in cycle 0.
  - Required: gpr_we=1, gpr_wa=3, gpr_wd=0x11111111 in cycle 1.
  - Required: gpr_we=0 in cycle 2 after valid drops.
- All three valid for 6 cycles, wa=1/2/3 respectively.
  - Required grant order: ALU, LSU, MDU, ALU, LSU, MDU.
  - Required: contention_cnt=6 when the ALU is grant-blocked while other sources are still held.
- LSU write to wa=0, wd=0xDEADBEEF.
  - Required: lsu_ready=1 and gpr_we=0 next cycle.
  - Required: the pointer advances so the MDU wins next over a simultaneous ALU request.
- ALU and MDU both target wa=5 in the same cycle with wd=0xA and 0xB, starting from reset.
  - Required: two consecutive gpr_we pulses carrying 0xA then 0xB.
- Reset asserted in the cycle after a grant.
  - Required: gpr_we=0, all readies 0 and contention_cnt=0 on the next edge.
- With WB_FWD_EN: gpr_we=1, gpr_wa=7, ra1=7, ra2=0.
  - Required: fwd1_hit=1, fwd2_hit=0, fwd_data=gpr_wd.
